// File: rtl/display_scan_7seg_pkg.sv
// ---------------------------------------------------------------------------
// display_scan_7seg_pkg
// Shared constants for the 6-digit multiplexed 7-segment driver.
//   NUM_DIG_DEF : default number of scanned digits
//   SEG_*       : active-low {g,f,e,d,c,b,a} patterns for 0-9, dash and off
// ---------------------------------------------------------------------------
package display_scan_7seg_pkg;

  localparam int NUM_DIG_DEF = 6;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

endpackage

// File: rtl/display_scan_7seg_seg7_decode.sv
// ---------------------------------------------------------------------------
// seg7_decode
// Combinational BCD nibble to active-low 7-segment pattern.
// Ports:
//   i_nib : 4-bit digit value
//   o_seg : {g,f,e,d,c,b,a}, active-low; 10-15 show a dash
// ---------------------------------------------------------------------------
module seg7_decode
  import display_scan_7seg_pkg::*;
(
  input  logic [3:0] i_nib,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_DASH;
    case (i_nib)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/display_scan_7seg.sv
// ---------------------------------------------------------------------------
// display_scan_7seg
// Time-multiplexed driver for a common-anode 7-segment display. Takes a
// tear-free snapshot of the packed BCD word once per frame and scans one
// digit per DIV-cycle slot, with optional leading-zero blanking.
// Ports:
//   clk      : system clock, rising edge
//   rst      : asynchronous active-high reset
//   dres     : packed BCD digits, digit 0 (units) in [3:0]
//   blank_en : 1 = suppress leading zeros (sampled live, not snapshotted)
//   an       : digit enables, active-low, at most one low
//   seg      : {g,f,e,d,c,b,a}, active-low
//   frame_tk : one-cycle pulse on the edge a new snapshot is loaded
// ---------------------------------------------------------------------------
module display_scan_7seg
  import display_scan_7seg_pkg::*;
#(
  parameter int NUM_DIG = NUM_DIG_DEF,
  parameter int DIV     = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4*NUM_DIG-1:0] dres,
  input  logic                 blank_en,
  output logic [NUM_DIG-1:0]   an,
  output logic [6:0]           seg,
  output logic                 frame_tk
);

  localparam int CNT_W = $clog2(DIV);
  localparam int IDX_W = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIG - 1);

  logic [CNT_W-1:0]     r_cnt;
  logic [IDX_W-1:0]     r_idx;
  logic [4*NUM_DIG-1:0] r_snap;
  logic                 r_load_pend;
  logic [NUM_DIG-1:0]   r_an;
  logic [6:0]           r_seg;
  logic                 r_frame_tk;

  logic                 w_tick;
  logic                 w_load;
  logic [3:0]           w_nib;
  logic [6:0]           w_seg;
  logic [NUM_DIG-1:0]   w_lz;
  logic                 w_blank;
  logic [NUM_DIG-1:0]   w_an;

  assign w_tick = (r_cnt == CNT_MAX);
  assign w_load = r_load_pend || (w_tick && (r_idx == IDX_MAX));

  always_comb begin
    w_nib = '0;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (r_idx == IDX_W'(i)) w_nib = r_snap[4*i +: 4];
    end
  end

  // w_lz[i] = 1 when nibbles i..NUM_DIG-1 are all zero (a leading-zero run
  // reaching down to digit i). Any non-zero value, including invalid BCD,
  // breaks the run.
  always_comb begin
    logic acc;
    acc  = 1'b1;
    w_lz = '0;
    for (int i = NUM_DIG - 1; i >= 0; i--) begin
      acc     = acc && (r_snap[4*i +: 4] == 4'd0);
      w_lz[i] = acc;
    end
  end

  assign w_blank = blank_en && (r_idx != '0) && w_lz[r_idx];
  assign w_an    = ~(NUM_DIG'(1) << r_idx);

  seg7_decode u_dec (
    .i_nib (w_nib),
    .o_seg (w_seg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt       <= '0;
      r_idx       <= '0;
      r_snap      <= '0;
      r_load_pend <= 1'b1;
      r_an        <= '1;
      r_seg       <= SEG_OFF;
      r_frame_tk  <= 1'b0;
    end else begin
      r_cnt       <= w_tick ? '0 : r_cnt + CNT_W'(1);
      if (w_tick) r_idx <= (r_idx == IDX_MAX) ? '0 : r_idx + IDX_W'(1);
      r_load_pend <= 1'b0;
      r_frame_tk  <= w_load;
      if (w_load) r_snap <= dres;
      r_an        <= w_blank ? '1 : w_an;
      r_seg       <= w_blank ? SEG_OFF : w_seg;
    end
  end

  assign an       = r_an;
  assign seg      = r_seg;
  assign frame_tk = r_frame_tk;

endmodule

// File: tb/tb_display_scan_7seg.sv
module tb_display_scan_7seg;

  localparam int NUM_DIG = 6;
  localparam int DIV     = 4;
  localparam int FRAME   = DIV * NUM_DIG;

  logic        clk;
  logic        rst;
  logic [23:0] dres;
  logic        blank_en;
  logic [5:0]  an;
  logic [6:0]  seg;
  logic        frame_tk;

  int n_chk  = 0;
  int n_fail = 0;

  display_scan_7seg #(.NUM_DIG(NUM_DIG), .DIV(DIV)) dut (
    .clk      (clk),
    .rst      (rst),
    .dres     (dres),
    .blank_en (blank_en),
    .an       (an),
    .seg      (seg),
    .frame_tk (frame_tk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Segment table straight from the digit glyph list; 10-15 are dashes.
  logic [6:0] seg_tbl [16];
  initial begin
    seg_tbl[0] = 7'h40; seg_tbl[1] = 7'h79; seg_tbl[2] = 7'h24; seg_tbl[3] = 7'h30;
    seg_tbl[4] = 7'h19; seg_tbl[5] = 7'h12; seg_tbl[6] = 7'h02; seg_tbl[7] = 7'h78;
    seg_tbl[8] = 7'h00; seg_tbl[9] = 7'h10;
    for (int i = 10; i < 16; i++) seg_tbl[i] = 7'h3F;
  end

  // Reference model: time since reset release, in clock edges, determines
  // which digit is shown and when a frame snapshot is taken.
  int          m_edge  = 0;
  logic [23:0] m_snap  = '0;
  bit          m_valid = 0;
  logic [5:0]  exp_an;
  logic [6:0]  exp_seg;
  logic        exp_ft;
  int          ft_cnt  = 0;

  always @(negedge clk) begin
    int idx, hi, nib;
    bit blanked, load;
    chk("an_onehot", ($countones(~an) <= 1), 1);
    if (rst) begin
      chk("rst_an", an, 6'h3F);
      chk("rst_seg", seg, 7'h7F);
      chk("rst_ft", frame_tk, 0);
      m_edge  = 0;
      m_snap  = '0;
      m_valid = 0;
    end else begin
      if (m_valid) begin
        chk("model_an", an, exp_an);
        chk("model_seg", seg, exp_seg);
        chk("model_ft", frame_tk, exp_ft);
      end
      if (frame_tk) ft_cnt++;
      m_edge++;
      idx  = ((m_edge - 1) / DIV) % NUM_DIG;
      load = (m_edge == 1) || (m_edge % FRAME == 0);
      hi = -1;
      for (int i = 0; i < NUM_DIG; i++) if (((m_snap >> (4*i)) & 24'hF) != 0) hi = i;
      blanked = blank_en && (idx > 0) && (idx > hi);
      nib     = int'((m_snap >> (4*idx)) & 24'hF);
      exp_an  = blanked ? 6'h3F : (~(6'b1 << idx));
      exp_seg = blanked ? 7'h7F : seg_tbl[nib];
      exp_ft  = load;
      if (load) m_snap = dres;
      m_valid = 1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ft();
    int n = 0;
    do begin
      step(1);
      n++;
    end while (!frame_tk && n < 2*FRAME);
    chk("frame_tk_seen", frame_tk, 1);
  endtask

  // Checks the first cycle of each slot of the frame that starts next.
  task automatic run_frame(input string name, input logic [41:0] segs, input logic [5:0] blk);
    logic [5:0] ea;
    step(1);
    for (int k = 0; k < NUM_DIG; k++) begin
      ea = blk[k] ? 6'h3F : ~(6'b1 << k);
      chk({name, "_an"}, an, ea);
      chk({name, "_seg"}, seg, segs[7*k +: 7]);
      if (k < NUM_DIG - 1) step(DIV);
    end
  endtask

  initial begin
    int ft0;
    logic [23:0] v;
    rst = 1'b1; dres = 24'h000000; blank_en = 1'b0;
    step(3);
    chk("t1_rst_an", an, 6'h3F);
    chk("t1_rst_seg", seg, 7'h7F);
    ft0 = ft_cnt;
    rst = 1'b0;
    step(2);
    chk("t1_an", an, 6'h3E);
    chk("t1_seg", seg, 7'h40);
    chk("t1_ft_once", ft_cnt - ft0, 1);

    dres = 24'h123456;
    wait_ft();
    run_frame("t2", {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}, 6'b000000);

    dres = 24'h000042; blank_en = 1'b1;
    wait_ft();
    run_frame("t3b", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24}, 6'b111100);
    blank_en = 1'b0;
    wait_ft();
    run_frame("t3n", {7'h40, 7'h40, 7'h40, 7'h40, 7'h19, 7'h24}, 6'b000000);

    dres = 24'h0000A7;
    wait_ft();
    run_frame("t4n", {7'h40, 7'h40, 7'h40, 7'h40, 7'h3F, 7'h78}, 6'b000000);
    blank_en = 1'b1;
    wait_ft();
    run_frame("t4b", {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h3F, 7'h78}, 6'b111100);

    blank_en = 1'b0; dres = 24'h111111;
    wait_ft();
    step(1 + 2*DIV);
    dres = 24'h999999;
    for (int k = 2; k < NUM_DIG; k++) begin
      chk("t5_old_seg", seg, 7'h79);
      if (k < NUM_DIG - 1) step(DIV);
    end
    wait_ft();
    step(1);
    chk("t5_new_seg", seg, 7'h10);

    dres = 24'h222222;
    wait_ft();
    step(1 + 3*DIV);
    chk("t6_slot3_an", an, 6'h37);
    dres = 24'h654321;
    rst  = 1'b1;
    #1;
    chk("t6_async_an", an, 6'h3F);
    chk("t6_async_seg", seg, 7'h7F);
    step(1);
    rst = 1'b0;
    step(2);
    chk("t6_restart_an", an, 6'h3E);
    chk("t6_restart_seg", seg, 7'h79);

    // Randomised phase: the reference model checks every cycle.
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        v = 24'($urandom);
        dres = v & (24'hFFFFFF >> (4 * $urandom_range(0, 6)));
      end
      if ($urandom_range(0, 9) == 0) blank_en = ~blank_en;
      if ($urandom_range(0, 99) == 0) begin
        rst = 1'b1;
        step(1);
        rst = 1'b0;
      end else begin
        step(1);
      end
    end

    step(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
